// File: rtl/qcl_sync_pkg.sv
// qcl_sync_pkg
//   Shared types and constants for the qcl_sync_filter input conditioner.
//   - edge_e               : edge classification produced by each filter channel
//   - QCL_SYNC_MIN_STAGES  : smallest synchroniser depth accepted at elaboration
package qcl_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    localparam int QCL_SYNC_MIN_STAGES = 2;

endpackage

// File: rtl/qcl_pipe.sv
// qcl_pipe
//   Plain register pipeline, used as a multi-bit synchroniser. There is no
//   logic between stages, so each bit is an independent flop chain.
//   Ports:
//     clk_i   in  1        clock
//     reset_i in  1        synchronous active-high reset (loads init_val_p)
//     d_i     in  width_p  pipeline input
//     q_o     out width_p  output of the last stage
module qcl_pipe #(
    parameter int                 width_p    = 1,
    parameter int                 stages_p   = 2,
    parameter logic [width_p-1:0] init_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] stage_q [stages_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < stages_p; i++) begin
                stage_q[i] <= init_val_p;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < stages_p; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[stages_p-1];

endmodule

// File: rtl/qcl_sync_filter_ch.sv
// qcl_sync_filter_ch
//   One glitch-filter channel. A new level on the synchronised input is only
//   accepted after it has differed from the current level for filt_cycles_p
//   consecutive cycles; any reversion restarts the count.
//   Ports:
//     clk_i   in  1  clock
//     reset_i in  1  synchronous active-high reset
//     s_i     in  1  synchronised input
//     en_i    in  1  0 freezes the channel (count cleared, level held)
//     lvl_o   out 1  filtered level (registered)
//     rise_o  out 1  one-cycle pulse coincident with lvl_o going 0->1
//     fall_o  out 1  one-cycle pulse coincident with lvl_o going 1->0
module qcl_sync_filter_ch
    import qcl_sync_pkg::*;
#(
    parameter int   filt_cycles_p = 4,
    parameter logic init_val_p    = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic s_i,
    input  logic en_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W    = (filt_cycles_p > 1) ? $clog2(filt_cycles_p) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(filt_cycles_p - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_d;
    edge_e            edge_d;

    // The counter compares against the terminal value instead of wrapping,
    // so the level update and edge pulse happen on the same edge.
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_o;
        edge_d = EDGE_NONE;
        if (en_i && (s_i != lvl_o)) begin
            if (cnt_q == CNT_TERM) begin
                lvl_d  = s_i;
                edge_d = s_i ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            lvl_o  <= init_val_p;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_o  <= lvl_d;
            rise_o <= (edge_d == EDGE_RISE);
            fall_o <= (edge_d == EDGE_FALL);
        end
    end

endmodule

// File: rtl/qcl_sync_filter.sv
// qcl_sync_filter
//   Multi-channel input conditioner: synchronises channels_p asynchronous
//   inputs into clk_i and glitch-filters each one, producing a clean level
//   plus single-cycle rise/fall pulses.
//   Optional feature macro: QCL_SYNC_FILTER_STICKY_EN adds sticky event flags.
//   Ports:
//     clk_i        in  1           clock, all logic on posedge
//     reset_i      in  1           synchronous active-high reset
//     async_i      in  channels_p  raw asynchronous inputs
//     en_i         in  channels_p  per-channel enable
//     lvl_o        out channels_p  filtered level
//     rise_o       out channels_p  0->1 event pulse
//     fall_o       out channels_p  1->0 event pulse
//     sticky_o     out channels_p  latched event flags (sticky build only)
//     sticky_clr_i in  channels_p  per-channel sticky clear (sticky build only)
module qcl_sync_filter
    import qcl_sync_pkg::*;
#(
    parameter int                    channels_p    = 1,
    parameter int                    sync_stages_p = 2,
    parameter int                    filt_cycles_p = 4,
    parameter logic [channels_p-1:0] init_val_p    = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [channels_p-1:0] async_i,
    input  logic [channels_p-1:0] en_i,
    output logic [channels_p-1:0] lvl_o,
    output logic [channels_p-1:0] rise_o,
`ifdef QCL_SYNC_FILTER_STICKY_EN
    output logic [channels_p-1:0] fall_o,
    output logic [channels_p-1:0] sticky_o,
    input  logic [channels_p-1:0] sticky_clr_i
`else
    output logic [channels_p-1:0] fall_o
`endif
);

    if (sync_stages_p < QCL_SYNC_MIN_STAGES) begin : g_bad_stages
        $error("qcl_sync_filter: sync_stages_p must be >= %0d", QCL_SYNC_MIN_STAGES);
    end
    if (filt_cycles_p < 1) begin : g_bad_filt
        $error("qcl_sync_filter: filt_cycles_p must be >= 1");
    end

    logic [channels_p-1:0] sync_s;

    qcl_pipe #(
        .width_p    (channels_p),
        .stages_p   (sync_stages_p),
        .init_val_p (init_val_p)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (async_i),
        .q_o     (sync_s)
    );

    for (genvar c = 0; c < channels_p; c++) begin : g_ch
        qcl_sync_filter_ch #(
            .filt_cycles_p (filt_cycles_p),
            .init_val_p    (init_val_p[c])
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .s_i     (sync_s[c]),
            .en_i    (en_i[c]),
            .lvl_o   (lvl_o[c]),
            .rise_o  (rise_o[c]),
            .fall_o  (fall_o[c])
        );
    end

`ifdef QCL_SYNC_FILTER_STICKY_EN
    // Set term is OR-ed in after the clear so an event wins over a clear.
    logic [channels_p-1:0] sticky_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr_i) | rise_o | fall_o;
        end
    end

    assign sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_qcl_sync_filter.sv
module tb_qcl_sync_filter;

    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] async_in;
    logic [CH-1:0] en;
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
`ifdef QCL_SYNC_FILTER_STICKY_EN
    logic [CH-1:0] sticky;
    logic [CH-1:0] sticky_clr;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qcl_sync_filter #(
        .channels_p    (CH),
        .sync_stages_p (2),
        .filt_cycles_p (4),
        .init_val_p    (2'b00)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .async_i      (async_in),
        .en_i         (en),
        .lvl_o        (lvl),
        .rise_o       (rise),
`ifdef QCL_SYNC_FILTER_STICKY_EN
        .fall_o       (fall),
        .sticky_o     (sticky),
        .sticky_clr_i (sticky_clr)
`else
        .fall_o       (fall)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        async_in = '0;
        en       = '1;
`ifdef QCL_SYNC_FILTER_STICKY_EN
        sticky_clr = '0;
`endif
        do_reset();

        // Reset state
        check("reset_lvl", lvl, 2'b00);
        check("reset_rise", rise, 2'b00);
        check("reset_fall", fall, 2'b00);
`ifdef QCL_SYNC_FILTER_STICKY_EN
        check("reset_sticky", sticky, 2'b00);
`endif

        // Held 1 on ch0: level and rise pulse at edge 6 only
        async_in = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("hold_lvl_k%0d", k), lvl, (k >= 6) ? 2'b01 : 2'b00);
            check($sformatf("hold_rise_k%0d", k), rise, (k == 6) ? 2'b01 : 2'b00);
            check($sformatf("hold_fall_k%0d", k), fall, 2'b00);
`ifdef QCL_SYNC_FILTER_STICKY_EN
            check($sformatf("hold_sticky_k%0d", k), sticky, (k >= 7) ? 2'b01 : 2'b00);
`endif
        end

        // 3-cycle pulse on ch1 is swallowed; ch0 stays high
        async_in = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) async_in = 2'b01;
            step();
            check($sformatf("glitch_lvl_k%0d", k), lvl, 2'b01);
            check($sformatf("glitch_edges_k%0d", k), rise | fall, 2'b00);
        end

`ifdef QCL_SYNC_FILTER_STICKY_EN
        // Fall on ch0 with a clear in the same cycle: set wins, then clear takes effect
        async_in = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("stk_fall_k%0d", k), fall, (k == 6) ? 2'b01 : 2'b00);
        end
        sticky_clr = 2'b01;
        step();
        check("stk_set_wins", sticky, 2'b01);
        step();
        check("stk_cleared", sticky, 2'b00);
        sticky_clr = 2'b00;
        step();
        check("stk_stays_clear", sticky, 2'b00);
`else
        // Fall on ch0
        async_in = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("fall_lvl_k%0d", k), lvl, (k >= 6) ? 2'b00 : 2'b01);
            check($sformatf("fall_fall_k%0d", k), fall, (k == 6) ? 2'b01 : 2'b00);
            check($sformatf("fall_rise_k%0d", k), rise, 2'b00);
        end
`endif

        // Pattern 1,1,1,0,1,1,1,1 restarts the count; level rises at edge 10
        do_reset();
        begin
            logic [7:0] pat;
            pat = 8'b1111_0111; // bit k-1 applied before edge k
            for (int k = 1; k <= 12; k++) begin
                async_in = (k <= 8) ? {1'b0, pat[k-1]} : 2'b01;
                step();
                check($sformatf("pat_lvl_k%0d", k), lvl, (k >= 10) ? 2'b01 : 2'b00);
                check($sformatf("pat_rise_k%0d", k), rise, (k == 10) ? 2'b01 : 2'b00);
            end
        end

        // Disabled channel ignores input, then reports it 4 edges after enable
        do_reset();
        en       = 2'b10;
        async_in = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("dis_lvl_k%0d", k), lvl, 2'b00);
            check($sformatf("dis_rise_k%0d", k), rise, 2'b00);
        end
        en = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("reen_lvl_k%0d", k), lvl, (k >= 4) ? 2'b01 : 2'b00);
            check($sformatf("reen_rise_k%0d", k), rise, (k == 4) ? 2'b01 : 2'b00);
        end

        // Reset with count at 3: no pulse, full window afterwards
        do_reset();
        async_in = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        check("pre_rst_lvl", lvl, 2'b00);
        reset = 1'b1;
        step();
        check("mid_rst_lvl", lvl, 2'b00);
        check("mid_rst_rise", rise, 2'b00);
        check("mid_rst_fall", fall, 2'b00);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("post_rst_lvl_k%0d", k), lvl, (k >= 6) ? 2'b01 : 2'b00);
            check($sformatf("post_rst_rise_k%0d", k), rise, (k == 6) ? 2'b01 : 2'b00);
        end

        // Simultaneous events on both channels
        do_reset();
        async_in = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("both_rise_k%0d", k), rise, (k == 6) ? 2'b11 : 2'b00);
        end
        async_in = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("both_fall_k%0d", k), fall, (k == 6) ? 2'b11 : 2'b00);
            check($sformatf("both_lvl_k%0d", k), lvl, (k >= 6) ? 2'b00 : 2'b11);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
